// File: rtl/hdlverifier_reg_pkg.sv
// Shared address-map helpers and CTRL register bit positions for the
// hdlverifier register bank.
package hdlverifier_reg_pkg;

  localparam int COMMIT_BIT   = 0;
  localparam int SNAPSHOT_BIT = 1;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_CTRL   = 2'd1,
    ADDR_STATUS = 2'd2,
    ADDR_BAD    = 2'd3
  } addr_kind_e;

  function automatic int ctrl_offset(input int num_regs);
    return num_regs;
  endfunction

  function automatic int status_offset(input int num_regs);
    return num_regs + 1;
  endfunction

endpackage

// File: rtl/hdlverifier_reg_slot.sv
// One user register: shadow copy, dirty flag, active output and its
// one-cycle update strobe.
module hdlverifier_reg_slot #(
  parameter int DATA_WIDTH  = 32,
  parameter int AUTO_COMMIT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  commit,
  output logic [DATA_WIDTH-1:0] active,
  output logic                  dirty,
  output logic                  strobe
);

  logic [DATA_WIDTH-1:0] shadow;
  logic                  do_load;
  logic [DATA_WIDTH-1:0] load_val;

  // With auto-commit the shadow is bypassed and the write lands directly.
  assign do_load  = (AUTO_COMMIT != 0) ? wr : (commit & dirty);
  assign load_val = (AUTO_COMMIT != 0) ? wdata : shadow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      dirty  <= 1'b0;
      active <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= do_load;
      if (do_load) begin
        active <= load_val;
        dirty  <= 1'b0;
      end
      if (wr && (AUTO_COMMIT == 0)) begin
        shadow <= wdata;
        dirty  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdlverifier_reg_bank.sv
// Register bank with shadowed user registers, CTRL-triggered commit and
// input snapshot, plus a STATUS view of pending (dirty) registers.
module hdlverifier_reg_bank
  import hdlverifier_reg_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int AUTO_COMMIT = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           write,
  input  logic                           read,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  output logic                           err,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] user_data_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] user_data_out,
  output logic [NUM_REGS-1:0]            user_wr_strobe,
  output logic                           commit_pulse
);

  if (NUM_REGS < 1 || NUM_REGS > DATA_WIDTH) begin : g_bad_num_regs
    $error("hdlverifier_reg_bank: NUM_REGS must be in 1..DATA_WIDTH");
  end
  if ((2 ** ADDR_WIDTH) < NUM_REGS + 2) begin : g_bad_addr_width
    $error("hdlverifier_reg_bank: ADDR_WIDTH too small for NUM_REGS+2 addresses");
  end
  if (DATA_WIDTH < 2) begin : g_bad_data_width
    $error("hdlverifier_reg_bank: DATA_WIDTH must hold the CTRL bits");
  end

  localparam logic [ADDR_WIDTH-1:0] NREG_A   = ADDR_WIDTH'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] CTRL_A   = ADDR_WIDTH'(ctrl_offset(NUM_REGS));
  localparam logic [ADDR_WIDTH-1:0] STATUS_A = ADDR_WIDTH'(status_offset(NUM_REGS));

  logic                  accept_en;
  logic                  acc_wr;
  logic                  acc_rd;
  addr_kind_e            kind;
  logic                  do_commit;
  logic                  do_snap;
  logic [NUM_REGS-1:0]   dirty;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] snapshot [NUM_REGS];

  // Blocks the strobe sampled on the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) accept_en <= 1'b0;
    else       accept_en <= 1'b1;
  end

  assign acc_wr = write & accept_en;
  assign acc_rd = read & accept_en;

  always_comb begin
    kind = ADDR_BAD;
    if (addr < NREG_A)          kind = ADDR_DATA;
    else if (addr == CTRL_A)    kind = ADDR_CTRL;
    else if (addr == STATUS_A)  kind = ADDR_STATUS;
  end

  assign do_commit = acc_wr && (kind == ADDR_CTRL) && wdata[COMMIT_BIT];
  assign do_snap   = acc_wr && (kind == ADDR_CTRL) && wdata[SNAPSHOT_BIT];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    hdlverifier_reg_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .AUTO_COMMIT(AUTO_COMMIT)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .wr    (acc_wr && (kind == ADDR_DATA) && (addr == ADDR_WIDTH'(i))),
      .wdata (wdata),
      .commit(do_commit),
      .active(user_data_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .dirty (dirty[i]),
      .strobe(user_wr_strobe[i])
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset)        snapshot[i] <= '0;
      else if (do_snap) snapshot[i] <= user_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read mux sees pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    case (kind)
      ADDR_DATA: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr == ADDR_WIDTH'(i)) rd_val = snapshot[i];
        end
      end
      ADDR_STATUS: rd_val[NUM_REGS-1:0] = dirty;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata        <= '0;
      rvalid       <= 1'b0;
      err          <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      rvalid       <= acc_rd;
      err          <= (acc_rd | acc_wr) && (kind == ADDR_BAD);
      commit_pulse <= do_commit;
      if (acc_rd) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_hdlverifier_reg_bank.sv
// Directed self-checking bench for hdlverifier_reg_bank: default instance
// plus an auto-commit instance sharing clock, reset and address/data.
module tb_hdlverifier_reg_bank;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 5;

  logic              clk;
  logic              reset;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic              write;
  logic              read;
  logic [NR*DW-1:0]  udi;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic              err;
  logic [NR*DW-1:0]  udo;
  logic [NR-1:0]     strobe;
  logic              commit_p;

  logic              wr_ac;
  logic              rd_ac;
  logic [NR*DW-1:0]  udi_ac;
  logic [DW-1:0]     rdata_ac;
  logic              rvalid_ac;
  logic              err_ac;
  logic [NR*DW-1:0]  udo_ac;
  logic [NR-1:0]     strobe_ac;
  logic              commit_ac;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_out [NR];

  hdlverifier_reg_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .AUTO_COMMIT(0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .write(write), .read(read),
    .rdata(rdata), .rvalid(rvalid), .err(err), .user_data_in(udi), .user_data_out(udo),
    .user_wr_strobe(strobe), .commit_pulse(commit_p)
  );

  hdlverifier_reg_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .AUTO_COMMIT(1)) dut_ac (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .write(wr_ac), .read(rd_ac),
    .rdata(rdata_ac), .rvalid(rvalid_ac), .err(err_ac), .user_data_in(udi_ac),
    .user_data_out(udo_ac), .user_wr_strobe(strobe_ac), .commit_pulse(commit_ac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] pack_exp();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = exp_out[i];
    return v;
  endfunction

  task automatic drive(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    write = w;
    read  = r;
    addr  = a;
    wdata = d;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) exp_out[i] = '0;
    reset  = 1'b1;
    udi    = '0;
    udi_ac = '0;
    wr_ac  = 1'b0;
    rd_ac  = 1'b0;
    drive(1'b1, 1'b0, 5'd2, 32'h0000_0011);
    tick();
    tick();

    // reset state
    chk_vec("rst_out", udo, '0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_strobe", 32'(strobe), 32'h0);
    chk("rst_commit", 32'(commit_p), 32'h0);
    chk_vec("rst_out_ac", udo_ac, '0);

    // write presented while reset releases is dropped
    reset = 1'b0;
    tick();
    drive(1'b0, 1'b1, 5'd9, 32'h0);
    tick();
    chk("release_status", rdata, 32'h0);
    chk("release_rvalid", 32'(rvalid), 32'h1);

    // shadow write does not touch active output
    drive(1'b1, 1'b0, 5'd2, 32'hDEAD_BEEF);
    tick();
    chk_vec("shadow_out", udo, pack_exp());
    chk("shadow_strobe", 32'(strobe), 32'h0);
    chk("shadow_rvalid", 32'(rvalid), 32'h0);
    drive(1'b0, 1'b1, 5'd9, 32'h0);
    tick();
    chk("status_dirty2", rdata, 32'h4);
    chk("status_rvalid", 32'(rvalid), 32'h1);
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("idle_rvalid", 32'(rvalid), 32'h0);
    chk("idle_rdata_hold", rdata, 32'h4);

    // commit
    drive(1'b1, 1'b0, 5'd8, 32'h1);
    tick();
    exp_out[2] = 32'hDEAD_BEEF;
    chk_vec("commit_out", udo, pack_exp());
    chk("commit_strobe", 32'(strobe), 32'h04);
    chk("commit_pulse", 32'(commit_p), 32'h1);
    drive(1'b0, 1'b1, 5'd9, 32'h0);
    tick();
    chk("commit_pulse_end", 32'(commit_p), 32'h0);
    chk("commit_strobe_end", 32'(strobe), 32'h0);
    chk("status_clean", rdata, 32'h0);

    // simultaneous write and read of the same data address
    drive(1'b1, 1'b1, 5'd3, 32'h0000_0033);
    tick();
    chk("wr_rd_rdata", rdata, 32'h0);
    chk("wr_rd_rvalid", 32'(rvalid), 32'h1);
    drive(1'b0, 1'b1, 5'd9, 32'h0);
    tick();
    chk("status_dirty3", rdata, 32'h08);

    // commit of reg3, then commit with nothing dirty
    drive(1'b1, 1'b0, 5'd8, 32'h1);
    tick();
    exp_out[3] = 32'h0000_0033;
    chk_vec("commit3_out", udo, pack_exp());
    chk("commit3_strobe", 32'(strobe), 32'h08);
    chk("commit3_pulse", 32'(commit_p), 32'h1);
    drive(1'b1, 1'b0, 5'd8, 32'h1);
    tick();
    chk("empty_commit_pulse", 32'(commit_p), 32'h1);
    chk("empty_commit_strobe", 32'(strobe), 32'h0);

    // snapshot
    udi[5*DW +: DW] = 32'h1234_5678;
    udi[0*DW +: DW] = 32'hCAFE_F00D;
    drive(1'b1, 1'b0, 5'd8, 32'h2);
    tick();
    chk("snap_no_commit", 32'(commit_p), 32'h0);
    chk_vec("snap_out_same", udo, pack_exp());
    udi = '0;
    drive(1'b0, 1'b1, 5'd5, 32'h0);
    tick();
    chk("snap_rd5", rdata, 32'h1234_5678);
    chk("snap_rd5_rvalid", 32'(rvalid), 32'h1);
    drive(1'b0, 1'b1, 5'd0, 32'h0);
    tick();
    chk("snap_rd0", rdata, 32'hCAFE_F00D);
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("snap_rvalid_low", 32'(rvalid), 32'h0);
    chk("snap_rdata_hold", rdata, 32'hCAFE_F00D);
    drive(1'b0, 1'b1, 5'd8, 32'h0);
    tick();
    chk("ctrl_read_zero", rdata, 32'h0);
    chk("ctrl_read_err", 32'(err), 32'h0);

    // invalid read
    drive(1'b0, 1'b1, 5'd31, 32'h0);
    tick();
    chk("bad_rd_rvalid", 32'(rvalid), 32'h1);
    chk("bad_rd_rdata", rdata, 32'h0);
    chk("bad_rd_err", 32'(err), 32'h1);
    chk_vec("bad_rd_out", udo, pack_exp());
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("bad_rd_err_end", 32'(err), 32'h0);

    // invalid write
    drive(1'b1, 1'b0, 5'd20, 32'hFFFF_FFFF);
    tick();
    chk("bad_wr_err", 32'(err), 32'h1);
    chk("bad_wr_strobe", 32'(strobe), 32'h0);
    chk_vec("bad_wr_out", udo, pack_exp());
    drive(1'b0, 1'b1, 5'd9, 32'h0);
    tick();
    chk("bad_wr_status", rdata, 32'h0);
    chk("bad_wr_err_end", 32'(err), 32'h0);

    // write right after a commit re-dirties the register
    drive(1'b1, 1'b0, 5'd1, 32'h0000_0011);
    tick();
    drive(1'b1, 1'b0, 5'd8, 32'h1);
    tick();
    exp_out[1] = 32'h0000_0011;
    chk("recommit_strobe", 32'(strobe), 32'h02);
    drive(1'b1, 1'b0, 5'd1, 32'h0000_0022);
    tick();
    chk("post_commit_strobe", 32'(strobe), 32'h0);
    chk_vec("post_commit_out", udo, pack_exp());
    drive(1'b0, 1'b1, 5'd9, 32'h0);
    tick();
    chk("post_commit_status", rdata, 32'h02);

    // auto-commit instance
    drive(1'b0, 1'b0, 5'd0, 32'hA5A5_A5A5);
    wr_ac = 1'b1;
    tick();
    wr_ac = 1'b0;
    chk_vec("ac_out", udo_ac, {{(NR-1)*DW{1'b0}}, 32'hA5A5_A5A5});
    chk("ac_strobe", 32'(strobe_ac), 32'h01);
    chk("ac_commit", 32'(commit_ac), 32'h0);
    chk("ac_err", 32'(err_ac), 32'h0);
    chk_vec("ac_main_out", udo, pack_exp());
    tick();
    chk("ac_strobe_end", 32'(strobe_ac), 32'h0);
    chk("ac_rvalid", 32'(rvalid_ac), 32'h0);
    chk("ac_rdata", rdata_ac, 32'h0);

    // reset asserted with a commit pending
    drive(1'b1, 1'b0, 5'd1, 32'h0000_0077);
    tick();
    drive(1'b1, 1'b0, 5'd8, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) exp_out[i] = '0;
    chk_vec("async_rst_out", udo, pack_exp());
    chk_vec("async_rst_out_ac", udo_ac, '0);
    chk("async_rst_rdata", rdata, 32'h0);
    chk("async_rst_rvalid", 32'(rvalid), 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("rst_held_strobe", 32'(strobe), 32'h0);
    chk("rst_held_commit", 32'(commit_p), 32'h0);
    reset = 1'b0;
    tick();
    drive(1'b0, 1'b1, 5'd9, 32'h0);
    tick();
    chk("after_rst_status", rdata, 32'h0);
    chk("after_rst_rvalid", 32'(rvalid), 32'h1);
    chk("after_rst_strobe", 32'(strobe), 32'h0);
    chk("after_rst_commit", 32'(commit_p), 32'h0);
    chk_vec("after_rst_out", udo, pack_exp());
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdlverifier_reg_bank.md
HDLVERIFIER_REG_BANK -- requirements
Module: hdlverifier_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register word width.
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning count of user registers; legal range 1..DATA_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, meaning address width; elaboration error if 2**ADDR_WIDTH < NUM_REGS+2.
REQ-004 SHALL have parameter AUTO_COMMIT, default 0, meaning 1 = each write updates the active output directly (shadows bypassed).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports addr (input, ADDR_WIDTH, register address), wdata (input, DATA_WIDTH, write data), write (input, 1, write strobe), read (input, 1, read strobe).
REQ-008 SHALL have ports rdata (output, DATA_WIDTH, registered read data), rvalid (output, 1, one-cycle read-data-valid), err (output, 1, one-cycle bad-address pulse).
REQ-009 SHALL have port user_data_in, input, NUM_REGS*DATA_WIDTH, flattened inputs; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port user_data_out, output, NUM_REGS*DATA_WIDTH, flattened active outputs; same packing.
REQ-011 SHALL have ports user_wr_strobe (output, NUM_REGS, one-cycle pulse per active-register update) and commit_pulse (output, 1, one-cycle pulse per commit).

Function
REQ-012 Address map SHALL be: 0..NUM_REGS-1 = data registers; NUM_REGS = CTRL; NUM_REGS+1 = STATUS; all others invalid.
REQ-013 Write to data address i with AUTO_COMMIT=0 SHALL load shadow[i] and set dirty[i] on the next edge; active output unchanged.
REQ-014 Write to data address i with AUTO_COMMIT=1 SHALL load active[i] on the next edge and pulse user_wr_strobe[i] in the following cycle.
REQ-015 CTRL write with wdata[0]=1 SHALL copy every dirty shadow to active in one edge, clear dirty, pulse user_wr_strobe[i] for each dirty i and pulse commit_pulse, all one cycle after the write.
REQ-016 CTRL write with wdata[1]=1 SHALL capture all of user_data_in into the snapshot bank in one edge; both bits may be set together.
REQ-017 Commit with dirty all-zero SHALL still pulse commit_pulse, with user_wr_strobe all-zero.
REQ-018 Write to data address i in the same cycle as a commit is impossible (single address); a write to i arriving the cycle after a commit SHALL set dirty[i] afresh.
REQ-019 Read of data address i SHALL return snapshot[i]; read of CTRL SHALL return zero; read of STATUS SHALL return dirty zero-extended to DATA_WIDTH.
REQ-020 Read latency SHALL be exactly 1: rdata and rvalid valid the cycle after read; rdata holds its value while rvalid is low.
REQ-021 Read or write to an invalid address SHALL have no state effect and pulse err one cycle later; invalid read SHALL also pulse rvalid with rdata=0.
REQ-022 write and read together SHALL perform both; read returns pre-write state (STATUS read sees old dirty).
REQ-023 Back-to-back strobes every cycle SHALL be accepted with no stall; there is no ready signal.

Reset
REQ-024 Asserting reset SHALL immediately clear shadow, dirty, active, snapshot, rdata, rvalid, err, user_wr_strobe and commit_pulse to zero.
REQ-025 A write or read in the cycle reset deasserts SHALL be discarded; the first accepted strobe is on the following edge.
REQ-026 A commit in flight when reset asserts SHALL be abandoned with no strobe output.

Structure
REQ-027 Package hdlverifier_reg_pkg SHALL hold the CTRL/STATUS offset functions of NUM_REGS and the CTRL bit indices COMMIT_BIT=0, SNAPSHOT_BIT=1.
REQ-028 Per-register shadow/active/dirty/strobe logic SHALL be one sub-module, hdlverifier_reg_slot, instantiated NUM_REGS times via generate.

Verification
REQ-029 Defaults: write 0xDEADBEEF to addr 2 -> user_data_out reg2 stays 0, STATUS read returns 0x00000004.
REQ-030 Then CTRL write 0x1 -> next cycle reg2 output 0xDEADBEEF, user_wr_strobe=0x04, commit_pulse=1; STATUS then 0x0.
REQ-031 Drive user_data_in reg5=0x12345678, CTRL write 0x2, change input to 0, read addr 5 -> rdata 0x12345678, rvalid one cycle.
REQ-032 Read addr 31 -> rvalid=1, rdata=0, err=1 one cycle later; no output changes.
REQ-033 AUTO_COMMIT=1, write 0xA5A5A5A5 to addr 0 -> reg0 output updates next edge, user_wr_strobe=0x01 following cycle, commit_pulse stays 0.
REQ-034 Write addr 1 then assert reset mid-cycle before commit -> all outputs 0 asynchronously, STATUS read after release returns 0.
